seq_alu: RTL

- Multi-cycle, handshaked successor to the 16-function combinational 32-bit ALU.
- Width is parametrised. The opcode is widened to 5 bits.
- Adds iterative unsigned multiply, divide and remainder, plus registered result/flag outputs.
- Sits between the RISC decode stage and writeback. Valid/ready on both sides lets the core stall on long ops.

---
 rtl/seq_alu_pkg.sv | 33 +++
 rtl/seq_alu_comb.sv | 50 +++++
 rtl/seq_alu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state type for seq_alu.
// SEQ_ALU_MULDIV_EN widens the legal opcode range to include MUL/DIVU/REMU.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_NOR    = 5'd5;
  localparam logic [4:0] OP_NOT    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_INC    = 5'd10;
  localparam logic [4:0] OP_DEC    = 5'd11;
  localparam logic [4:0] OP_SLT    = 5'd12;
  localparam logic [4:0] OP_SGT    = 5'd13;
  localparam logic [4:0] OP_LUI    = 5'd14;
  localparam logic [4:0] OP_POPCNT = 5'd15;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_DIVU   = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [4:0] OP_LAST_LEGAL = OP_REMU;
`else
  localparam logic [4:0] OP_LAST_LEGAL = OP_POPCNT;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle ALU functions (opcodes 0-15); legality is decided by the caller.
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [4:0]   i_cmd,
  output logic [N-1:0] o_z
);

  localparam int SHW = $clog2(N);

  logic [SHW-1:0] w_sh;
  logic [N-1:0]   w_pop;

  assign w_sh = i_b[SHW-1:0];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + N'(i_a[i]);
    end
  end

  always_comb begin
    o_z = '0;
    case (i_cmd)
      OP_ADD:    o_z = i_a + i_b;
      OP_SUB:    o_z = i_a - i_b;
      OP_AND:    o_z = i_a & i_b;
      OP_OR:     o_z = i_a | i_b;
      OP_XOR:    o_z = i_a ^ i_b;
      OP_NOR:    o_z = ~(i_a | i_b);
      OP_NOT:    o_z = ~i_a;
      OP_SLL:    o_z = i_a << w_sh;
      OP_SRL:    o_z = i_a >> w_sh;
      OP_SRA:    o_z = $signed(i_a) >>> w_sh;
      OP_INC:    o_z = i_a + 1'b1;
      OP_DEC:    o_z = i_a - 1'b1;
      OP_SLT:    o_z = N'($signed(i_a) < $signed(i_b));
      OP_SGT:    o_z = N'($signed(i_a) > $signed(i_b));
      OP_LUI:    o_z = i_a << (N / 2);
      OP_POPCNT: o_z = w_pop;
      default:   o_z = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle ops plus an iterative MUL/DIVU/REMU
// engine that is only built when SEQ_ALU_MULDIV_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   CMD,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         zero,
  output logic         err
);

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_z;
  logic         r_err;

  logic [N-1:0] w_comb_z;
  logic [N-1:0] w_z_single;
  logic         w_err_single;
  logic         w_accept;
  logic         w_go_exec;
  logic         w_exec_done;
  logic [N-1:0] w_res;

  seq_alu_comb #(.N(N)) u_comb (
    .i_a   (A),
    .i_b   (B),
    .i_cmd (CMD),
    .o_z   (w_comb_z)
  );

  assign w_accept = in_valid && (r_state == IDLE);

  // Results that complete in the accept cycle, including divide-by-zero.
  always_comb begin
    w_z_single   = '0;
    w_err_single = 1'b1;
    if (CMD <= OP_POPCNT) begin
      w_z_single   = w_comb_z;
      w_err_single = 1'b0;
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (CMD == OP_DIVU) begin
      w_z_single = '1;
    end else if (CMD == OP_REMU) begin
      w_z_single = A;
    end
`endif
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = SHW + 1;

  logic [CW-1:0] r_cnt;
  logic [4:0]    r_op;
  logic [N-1:0]  r_p;   // product accumulator / partial remainder
  logic [N-1:0]  r_x;   // shifting multiplicand / dividend becoming quotient
  logic [N-1:0]  r_y;   // shifting multiplier / divisor
  logic [N:0]    w_rem_sh;
  logic [N-1:0]  w_diff;
  logic          w_fits;

  assign w_go_exec   = (CMD == OP_MUL) ||
                       (((CMD == OP_DIVU) || (CMD == OP_REMU)) && (B != '0));
  assign w_exec_done = (r_state == EXEC) && (r_cnt == '0);
  assign w_rem_sh    = {r_p, r_x[N-1]};
  assign w_fits      = w_rem_sh >= {1'b0, r_y};
  assign w_diff      = w_rem_sh[N-1:0] - r_y;
  assign w_res       = (r_op == OP_DIVU) ? r_x : r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= OP_ADD;
      r_p   <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_accept && w_go_exec) begin
      r_cnt <= CW'(N);
      r_op  <= CMD;
      r_p   <= '0;
      r_x   <= A;
      r_y   <= B;
    end else if ((r_state == EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op == OP_MUL) begin
        r_p <= r_p + (r_y[0] ? r_x : '0);
        r_x <= r_x << 1;
        r_y <= r_y >> 1;
      end else begin
        r_p <= w_fits ? w_diff : w_rem_sh[N-1:0];
        r_x <= {r_x[N-2:0], w_fits};
      end
    end
  end
`else
  assign w_go_exec   = 1'b0;
  assign w_exec_done = 1'b0;
  assign w_res       = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_go_exec ? EXEC : DONE;
      EXEC: if (w_exec_done) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_z     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !w_go_exec) begin
        r_z   <= w_z_single;
        r_err <= w_err_single;
      end else if (w_exec_done) begin
        r_z   <= w_res;
        r_err <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Z         = r_z;
  assign err       = r_err;
  // Qualified by DONE so the idle/reset value of zero stays low.
  assign zero      = (r_state == DONE) && (r_z == '0);

endmodule
